// File: rtl/cic_comb_chain.sv
// rtl/cic_comb_chain.sv - multi-stage, multi-channel CIC comb section at the decimated rate
//
// Cascades STAGES comb stages y[n] = x[n] - x[n-DELAY], each with an
// independent DELAY-deep history per time-interleaved channel. Valid and
// channel tag ride along with the data; latency is STAGES+1 cycles.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   in_valid   x/in_chan valid (decimated-rate strobe)
//   in_chan    channel tag of x, checked against the expected rotation
//   x          signed input sample, DATA_WIDTH bits (bit growth included)
//   out_valid  one-cycle pulse per output sample
//   out_chan   channel of y
//   y          signed comb output, OUT_WIDTH bits
//   seq_err    sticky channel-sequence error
//
// Optional build macro: CIC_COMB_CHAIN_ROUND_EN
//   Round half up (saturating on positive overflow) instead of truncating
//   when OUT_WIDTH < DATA_WIDTH.

module cic_comb_chain #(
  parameter int STAGES     = 3,
  parameter int DELAY      = 1,
  parameter int CHANNELS   = 1,
  parameter int DATA_WIDTH = 24,
  parameter int OUT_WIDTH  = 16,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [CH_W-1:0]              in_chan,
  input  logic signed [DATA_WIDTH-1:0] x,
  output logic                         out_valid,
  output logic [CH_W-1:0]              out_chan,
  output logic signed [OUT_WIDTH-1:0]  y,
  output logic                         seq_err
);

  // Index 0 is the input register; index k is the output of comb stage k.
  logic                  s_v [STAGES+1];
  logic [CH_W-1:0]       s_c [STAGES+1];
  logic [DATA_WIDTH-1:0] s_d [STAGES+1];

  // hist[k][c][0] is the newest input seen by stage k+1 for channel c.
  logic [DATA_WIDTH-1:0] hist [STAGES][CHANNELS][DELAY];

  logic [CH_W-1:0]       cnt;
  logic [DATA_WIDTH-1:0] fin;
  logic [OUT_WIDTH-1:0]  y_next;

  assign fin = s_d[STAGES];

  generate
    if (DATA_WIDTH > OUT_WIDTH) begin : g_reduce
`ifdef CIC_COMB_CHAIN_ROUND_EN
      localparam logic [DATA_WIDTH:0] HALF =
        (DATA_WIDTH+1)'(1) << (DATA_WIDTH - OUT_WIDTH - 1);
      logic [DATA_WIDTH:0] rnd;
      logic                unused_rnd;
      // One guard bit above the sign: a mismatch means the +half carried
      // past the positive full scale, which can only happen upwards.
      assign rnd        = {fin[DATA_WIDTH-1], fin} + HALF;
      assign y_next     = (rnd[DATA_WIDTH] != rnd[DATA_WIDTH-1])
                        ? {1'b0, {(OUT_WIDTH-1){1'b1}}}
                        : rnd[DATA_WIDTH-1 -: OUT_WIDTH];
      assign unused_rnd = ^rnd[DATA_WIDTH-OUT_WIDTH-1:0];
`else
      logic unused_lsbs;
      assign y_next      = fin[DATA_WIDTH-1 -: OUT_WIDTH];
      assign unused_lsbs = ^fin[DATA_WIDTH-OUT_WIDTH-1:0];
`endif
    end else begin : g_full
      assign y_next = fin;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      seq_err   <= 1'b0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      y         <= '0;
      for (int k = 0; k <= STAGES; k++) begin
        s_v[k] <= 1'b0;
        s_c[k] <= '0;
        s_d[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++)
        for (int c = 0; c < CHANNELS; c++)
          for (int j = 0; j < DELAY; j++)
            hist[k][c][j] <= '0;
    end else begin
      // Accept: the sample is tagged with the expected channel, not in_chan,
      // so a mis-sequenced source cannot corrupt another channel's history.
      s_v[0] <= in_valid;
      if (in_valid) begin
        s_c[0] <= cnt;
        s_d[0] <= x;
        cnt    <= (cnt == CH_W'(CHANNELS - 1)) ? '0 : cnt + 1'b1;
        if (CHANNELS > 1 && in_chan != cnt)
          seq_err <= 1'b1;
      end

      for (int k = 1; k <= STAGES; k++) begin
        s_v[k] <= s_v[k-1];
        if (s_v[k-1]) begin
          s_c[k] <= s_c[k-1];
          // Modulo-2^DATA_WIDTH difference; the wrap is what makes the CIC work.
          s_d[k] <= s_d[k-1] - hist[k-1][s_c[k-1]][DELAY-1];
          for (int j = DELAY - 1; j > 0; j--)
            hist[k-1][s_c[k-1]][j] <= hist[k-1][s_c[k-1]][j-1];
          hist[k-1][s_c[k-1]][0] <= s_d[k-1];
        end
      end

      out_valid <= s_v[STAGES];
      if (s_v[STAGES]) begin
        out_chan <= s_c[STAGES];
        y        <= y_next;
      end
    end
  end

endmodule

// File: doc/cic_comb_chain.md
Name: cic_comb_chain

Overview:
- Parametrised multi-stage CIC comb section. Runs at the decimated rate, downstream of the integrator/decimator.
- Cascades STAGES comb stages, each y[n] = x[n] - x[n-DELAY].
- Supports time-interleaved channels, with independent delay-line state per channel.
- Pipelined, valid-qualified. Final value is truncated, or optionally rounded, to OUT_WIDTH for the MSO sample path.

Parameters:
- STAGES, 3, number of cascaded comb stages (1..8).
- DELAY, 1, differential delay M per stage, in samples of the same channel (1..4).
- CHANNELS, 1, number of time-interleaved channels (1..16).
- DATA_WIDTH, 24, internal/input width; must already include CIC bit growth.
- OUT_WIDTH, 16, output width; OUT_WIDTH <= DATA_WIDTH.
- CH_W (localparam) = max(1, clog2(CHANNELS)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  x/in_chan valid this cycle (decimated-rate strobe).
- in_chan  in  CH_W  channel tag of x.
- x  in  DATA_WIDTH (signed)  input sample.
- out_valid  out  1  y/out_chan valid, one-cycle pulse per sample.
- out_chan  out  CH_W  channel of y.
- y  out  OUT_WIDTH (signed)  comb output.
- seq_err  out  1  sticky channel-sequence error.

Behaviour:
- Reset (rst_n=0 at clk edge): all delay lines, stage registers and valid pipeline are cleared.
  - Expected-channel counter = 0.
  - Outputs: out_valid=0, out_chan=0, y=0, seq_err=0.
  - Reset mid-stream discards all in-flight samples; no out_valid follows.
- Channel order:
  - Samples arrive in strict order 0,1,...,CHANNELS-1, then wrap to 0. The internal counter advances on every in_valid.
  - If in_chan != counter on an in_valid: seq_err is set (sticky until reset). The sample is still processed as the counter's channel, and the counter still advances.
  - CHANNELS=1: in_chan is ignored and seq_err stays 0.
- Stage k (1..STAGES):
  - Registered.
  - Per channel c, holds a DELAY-deep history of its own input.
  - On a valid sample for c: output = in - hist_c[DELAY-1], then hist_c shifts with in entering.
  - Histories of other channels are untouched.
- Arithmetic: all stage arithmetic is DATA_WIDTH two's complement with modulo wrap. No saturation and no width growth inside the chain; wrap is required for CIC correctness.
- Pipeline:
  - Valid and channel tag travel with data.
  - Sample accepted at edge n: stage k registers it at edge n+k, and y/out_valid/out_chan are registered at edge n+STAGES+1.
  - Latency is STAGES+1 cycles.
  - Throughput: one sample per cycle; in_valid may be high continuously.
- Gaps: no stage or delay line changes while its input valid is low. y and out_chan hold their last values; out_valid=0.
- Output reduction: y = final[DATA_WIDTH-1 -: OUT_WIDTH] (truncation toward -inf). If OUT_WIDTH == DATA_WIDTH, y = final.

Optional Feature:
- Macro: CIC_COMB_CHAIN_ROUND_EN.
- Defined, with OUT_WIDTH < DATA_WIDTH:
  - Add 2^(DATA_WIDTH-OUT_WIDTH-1) to final before taking the top OUT_WIDTH bits (round half up).
  - If the addition overflows positive, y saturates to 2^(OUT_WIDTH-1)-1.
  - Latency is unchanged; rounding happens in the output register.
- Undefined: plain truncation.
- OUT_WIDTH == DATA_WIDTH: both modes are identical.

Test Plan:
- Impulse (STAGES=3, DELAY=1, CHANNELS=1, DATA_WIDTH=OUT_WIDTH=16): x=1 then 0s, in_valid every cycle -> first out_valid 4 cycles after the x=1 edge; y = 1,-3,3,-1,0,0.
- Step plus gaps (same config): x=5 held, in_valid every 2nd cycle -> y = 5,-10,5,0,0. out_valid pulses every 2nd cycle and y holds its value between pulses.
- Wrap (STAGES=1, DATA_WIDTH=OUT_WIDTH=8): x=-128 then 127 -> y=-128, then -1 (255 wraps), no error.
- Multichannel (CHANNELS=2, DELAY=2, STAGES=1): ch0 gets 1,0,0,0; ch1 gets 2,2,2,2, interleaved -> ch0 y=1,0,-1,0; ch1 y=2,2,0,0. out_chan alternates 0,1; seq_err=0.
- Sequence error and reset:
  - Send in_chan=1 when 0 is expected -> seq_err=1 and stays 1 through later correct samples.
  - rst_n=0 for one cycle mid-stream -> seq_err=0, y=0; no out_valid for in-flight samples.
  - Next impulse reproduces the clean response.
- Rounding (STAGES=1, DATA_WIDTH=16, OUT_WIDTH=8, x previous 0):
  - x=0x0180 -> y=0x01 without the macro, 0x02 with it.
  - x=0x7FF0 -> 0x7F in both modes (saturation with the macro).
